// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline stall controller.
// Holds the controller state encoding, the default HALT opcode, a few MIPS
// opcode/funct constants used around the hazard logic, and the zero register.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1,
        DRAIN       = 2'd2,
        HALTED      = 2'd3
    } state_t;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3f;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_MULT = 6'h18;
    localparam logic [5:0] OP_DIV  = 6'h1a;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between EX and ID.
// Ports:
//   X_MemRead - instruction in EX is a load
//   X_rt      - load destination register in EX
//   D_rs/D_rt - source registers of the instruction in ID
//   hazard    - ID reads the register the EX load is about to write
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       X_MemRead,
    input  logic [4:0] X_rt,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    output logic       hazard
);

    // A load targeting $zero writes nothing, so it can never feed a consumer.
    assign hazard = X_MemRead && (X_rt != REG_ZERO) && (X_rt == D_rs || X_rt == D_rt);

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: prioritised freeze/bubble/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset                - rising-edge clock, synchronous active-high reset
//   D_op, D_rs, D_rt          - opcode and source registers of the instruction in ID
//   X_rt, X_MemRead           - load destination / load flag of the instruction in EX
//   X_branch_taken            - branch/jump resolved taken in EX
//   X_muldiv_start            - mult/div entered EX this cycle
//   muldiv_done               - mult/div result valid pulse
//   PC_enable, IFID_enable    - PC and IF/ID load enables
//   IFID_flush                - IF/ID loads a NOP
//   IDEX_enable, IDEX_bubble  - ID/EX load enable and NOP insert
//   EXMEM_bubble              - EX/MEM loads a NOP
//   halted                    - pipeline drained after HALT (held until reset)
//   muldiv_timeout            - sticky: mult/div never signalled done
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE    = HALT_OPCODE_DEFAULT,
    parameter int         DRAIN_CYCLES   = 3,
    parameter int         MULDIV_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] D_op,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [4:0] X_rt,
    input  logic       X_MemRead,
    input  logic       X_branch_taken,
    input  logic       X_muldiv_start,
    input  logic       muldiv_done,
    output logic       PC_enable,
    output logic       IFID_enable,
    output logic       IFID_flush,
    output logic       IDEX_enable,
    output logic       IDEX_bubble,
    output logic       EXMEM_bubble,
    output logic       halted,
    output logic       muldiv_timeout
);

    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] MULDIV_LAST = 8'(MULDIV_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       timeout_flag, timeout_set;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .X_MemRead (X_MemRead),
        .X_rt      (X_rt),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .hazard    (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            timeout_flag <= timeout_flag | timeout_set;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        timeout_set  = 1'b0;
        PC_enable    = 1'b1;
        IFID_enable  = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_enable  = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_bubble = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (X_branch_taken) begin
                    // Wrong-path instructions in IF and ID are squashed; a
                    // simultaneous muldiv start is on the wrong path too.
                    IFID_flush  = 1'b1;
                    IDEX_bubble = 1'b1;
                end else if (X_muldiv_start) begin
                    // A unit that finishes in its first cycle needs no freeze.
                    if (!muldiv_done) begin
                        PC_enable    = 1'b0;
                        IFID_enable  = 1'b0;
                        IDEX_enable  = 1'b0;
                        EXMEM_bubble = 1'b1;
                        cnt_nxt      = 8'd0;
                        state_nxt    = MULDIV_WAIT;
                    end
                end else if (D_op == HALT_OPCODE) begin
                    PC_enable   = 1'b0;
                    IFID_enable = 1'b0;
                    IDEX_bubble = 1'b1;
                    cnt_nxt     = 8'd0;
                    state_nxt   = DRAIN;
                end else if (load_use) begin
                    PC_enable   = 1'b0;
                    IFID_enable = 1'b0;
                    IDEX_bubble = 1'b1;
                end
            end
            MULDIV_WAIT: begin
                if (muldiv_done) begin
                    state_nxt = RUN;
                end else if (cnt == MULDIV_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    PC_enable    = 1'b0;
                    IFID_enable  = 1'b0;
                    IDEX_enable  = 1'b0;
                    EXMEM_bubble = 1'b1;
                    cnt_nxt      = cnt + 8'd1;
                end
            end
            DRAIN: begin
                PC_enable   = 1'b0;
                IFID_enable = 1'b0;
                IDEX_bubble = 1'b1;
                cnt_nxt     = cnt + 8'd1;
                state_nxt   = (cnt == DRAIN_LAST) ? HALTED : DRAIN;
            end
            HALTED: begin
                PC_enable   = 1'b0;
                IFID_enable = 1'b0;
                IDEX_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        // Reset overrides everything so the pipeline registers fill with NOPs.
        if (reset) begin
            PC_enable    = 1'b0;
            IFID_enable  = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_enable  = 1'b0;
            IDEX_bubble  = 1'b1;
            EXMEM_bubble = 1'b0;
            halted       = 1'b0;
        end
    end

    assign muldiv_timeout = timeout_flag & ~reset;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed and randomized checks of the stall controller.
module tb_pipeline_stall_controller;
    import pipeline_ctrl_pkg::*;

    localparam logic [5:0] HALT = 6'h3f;
    localparam int         DRN  = 3;
    localparam int         TMO  = 32;

    // Output vector order: PC, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_bubble, halted, timeout
    localparam logic [7:0] O_DEF    = 8'b1101_0000;
    localparam logic [7:0] O_RST    = 8'b0010_1000;
    localparam logic [7:0] O_STALL  = 8'b0001_1000;
    localparam logic [7:0] O_HALTED = 8'b0001_1010;
    localparam logic [7:0] O_BRANCH = 8'b1111_1000;
    localparam logic [7:0] O_FREEZE = 8'b0000_0100;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] D_op;
    logic [4:0] D_rs, D_rt, X_rt;
    logic       X_MemRead, X_branch_taken, X_muldiv_start, muldiv_done;
    logic       PC_enable, IFID_enable, IFID_flush, IDEX_enable, IDEX_bubble, EXMEM_bubble, halted, muldiv_timeout;
    logic [7:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .HALT_OPCODE    (HALT),
        .DRAIN_CYCLES   (DRN),
        .MULDIV_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .D_op           (D_op),
        .D_rs           (D_rs),
        .D_rt           (D_rt),
        .X_rt           (X_rt),
        .X_MemRead      (X_MemRead),
        .X_branch_taken (X_branch_taken),
        .X_muldiv_start (X_muldiv_start),
        .muldiv_done    (muldiv_done),
        .PC_enable      (PC_enable),
        .IFID_enable    (IFID_enable),
        .IFID_flush     (IFID_flush),
        .IDEX_enable    (IDEX_enable),
        .IDEX_bubble    (IDEX_bubble),
        .EXMEM_bubble   (EXMEM_bubble),
        .halted         (halted),
        .muldiv_timeout (muldiv_timeout)
    );

    assign outs = {PC_enable, IFID_enable, IFID_flush, IDEX_enable, IDEX_bubble, EXMEM_bubble, halted, muldiv_timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                         input logic mr, input logic br, input logic ms, input logic dn);
        D_op = op; D_rs = rs; D_rt = rt; X_rt = xrt;
        X_MemRead = mr; X_branch_taken = br; X_muldiv_start = ms; muldiv_done = dn;
    endtask

    task automatic idle();
        drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        @(negedge clk);
        total++;
        if (outs !== O_RST) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", outs, O_RST); end
        reset = 1'b0;
        #1;
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL after_reset_idle got=%b exp=%b", outs, O_DEF); end
        tick();
    endtask

    task automatic test_load_use();
        drive(OP_LW, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_STALL) begin bad++; $display("FAIL lu_rs got=%b exp=%b", outs, O_STALL); end
        tick();
        drive(OP_LW, 5'd5, 5'd7, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL lu_release got=%b exp=%b", outs, O_DEF); end
        tick();
        drive(6'h00, 5'd9, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_STALL) begin bad++; $display("FAIL lu_rt got=%b exp=%b", outs, O_STALL); end
        tick();
        drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL lu_zero_reg got=%b exp=%b", outs, O_DEF); end
        tick();
        drive(6'h00, 5'd5, 5'd6, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL lu_not_load got=%b exp=%b", outs, O_DEF); end
        tick();
    endtask

    task automatic test_branch_priority();
        drive(HALT, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_BRANCH) begin bad++; $display("FAIL br_over_halt_lu got=%b exp=%b", outs, O_BRANCH); end
        tick();
        drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== O_BRANCH) begin bad++; $display("FAIL br_over_muldiv got=%b exp=%b", outs, O_BRANCH); end
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            @(negedge clk);
            total++;
            if (outs !== O_DEF) begin bad++; $display("FAIL br_stays_run[%0d] got=%b exp=%b", i, outs, O_DEF); end
            tick();
        end
    endtask

    task automatic test_muldiv();
        for (int i = 0; i < 7; i++) begin
            drive((i == 3) ? HALT : 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, i == 2, i == 0, i == 5);
            @(negedge clk);
            total++;
            if (outs !== ((i < 5) ? O_FREEZE : O_DEF))
                begin bad++; $display("FAIL muldiv[%0d] got=%b exp=%b", i, outs, (i < 5) ? O_FREEZE : O_DEF); end
            tick();
        end
        drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL muldiv_instant got=%b exp=%b", outs, O_DEF); end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL muldiv_instant_next got=%b exp=%b", outs, O_DEF); end
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, i == 0, 1'b0);
            exp = (i < TMO) ? O_FREEZE : (i == TMO) ? O_DEF : (O_DEF | 8'd1);
            @(negedge clk);
            total++;
            if (outs !== exp) begin bad++; $display("FAIL timeout[%0d] got=%b exp=%b", i, outs, exp); end
            tick();
        end
        drive(6'h00, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (outs !== (O_STALL | 8'd1)) begin bad++; $display("FAIL timeout_run_lu got=%b exp=%b", outs, O_STALL | 8'd1); end
        tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        total++;
        if (outs !== O_RST) begin bad++; $display("FAIL timeout_reset got=%b exp=%b", outs, O_RST); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== O_DEF) begin bad++; $display("FAIL timeout_cleared got=%b exp=%b", outs, O_DEF); end
        tick();
    endtask

    task automatic test_halt_drain();
        for (int i = 0; i < 24; i++) begin
            drive(HALT, 5'd0, 5'd0, 5'd0, 1'b0, i == 10, i == 12, 1'b0);
            @(negedge clk);
            total++;
            if (outs !== ((i < 1 + DRN) ? O_STALL : O_HALTED))
                begin bad++; $display("FAIL halt[%0d] got=%b exp=%b", i, outs, (i < 1 + DRN) ? O_STALL : O_HALTED); end
            tick();
        end
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 2; i++) begin
            drive(HALT, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            total++;
            if (outs !== O_STALL) begin bad++; $display("FAIL mid_drain[%0d] got=%b exp=%b", i, outs, O_STALL); end
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== O_RST) begin bad++; $display("FAIL mid_drain_reset got=%b exp=%b", outs, O_RST); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            @(negedge clk);
            total++;
            if (outs !== O_DEF) begin bad++; $display("FAIL after_mid_drain[%0d] got=%b exp=%b", i, outs, O_DEF); end
            tick();
        end
    endtask

    // Reference model: tracks how long each multi-cycle activity has lasted
    // and derives the expected controls directly from the priority rules.
    task automatic test_random();
        bit         in_md, in_drain, is_halted, to_seen;
        int         md_cycles, drain_cycles;
        logic [7:0] exp;
        bit         lu;
        in_md = 0; in_drain = 0; is_halted = 0; to_seen = 0;
        md_cycles = 0; drain_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            reset          = (n == 0) || ($urandom_range(39) == 0);
            D_op           = ($urandom_range(59) == 0) ? HALT : 6'($urandom_range(62));
            D_rs           = 5'($urandom_range(3));
            D_rt           = 5'($urandom_range(3));
            X_rt           = 5'($urandom_range(3));
            X_MemRead      = $urandom_range(1) == 1;
            X_branch_taken = $urandom_range(7) == 0;
            X_muldiv_start = $urandom_range(9) == 0;
            muldiv_done    = $urandom_range(5) == 0;
            lu = X_MemRead && X_rt != 0 && (X_rt == D_rs || X_rt == D_rt);
            if (reset) begin
                exp = O_RST;
                in_md = 0; in_drain = 0; is_halted = 0; to_seen = 0;
            end else begin
                exp = 8'h00;
                if (is_halted) exp = O_HALTED;
                else if (in_drain) begin
                    exp = O_STALL;
                    drain_cycles++;
                    if (drain_cycles == DRN) begin in_drain = 0; is_halted = 1; end
                end else if (in_md) begin
                    md_cycles++;
                    if (muldiv_done) begin exp = O_DEF; in_md = 0; end
                    else if (md_cycles == TMO) begin exp = O_DEF; in_md = 0; end
                    else exp = O_FREEZE;
                end else if (X_branch_taken) exp = O_BRANCH;
                else if (X_muldiv_start) begin
                    exp = muldiv_done ? O_DEF : O_FREEZE;
                    if (!muldiv_done) begin in_md = 1; md_cycles = 0; end
                end else if (D_op == HALT) begin
                    exp = O_STALL; in_drain = 1; drain_cycles = 0;
                end else exp = lu ? O_STALL : O_DEF;
                exp[0] = to_seen;
                if (exp == O_DEF && !in_md && md_cycles == TMO && !muldiv_done && !X_branch_taken) to_seen = 1;
            end
            @(negedge clk);
            total++;
            if (outs !== exp) begin bad++; $display("FAIL random[%0d] got=%b exp=%b", n, outs, exp); end
            if (md_cycles == TMO) md_cycles = 0;
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_muldiv();
        test_timeout();
        test_halt_drain();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central sequencer for the 5-stage MIPS pipeline's freeze, bubble and flush controls. It merges four conditions into one prioritised set of pipeline-register controls:
- load-use hazards;
- taken-branch flushes;
- multi-cycle multiply/divide occupancy of EX;
- HALT drain.

It replaces ad-hoc combinational stall logic with one FSM. It sits beside the IF/ID, ID/EX and EX/MEM registers and drives their enable, bubble and flush inputs.

Parameters:
HALT_OPCODE, 6'h3f, opcode that starts the halt drain sequence
DRAIN_CYCLES, 3, cycles to let X/M/W retire before halted asserts (range 1..7)
MULDIV_TIMEOUT, 32, max cycles in MULDIV_WAIT before forced abort (range 2..255)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
D_op  in  6  opcode of the instruction in ID
D_rs  in  5  rs field of the instruction in ID
D_rt  in  5  rt field of the instruction in ID
X_rt  in  5  rt (load destination) of the instruction in EX
X_MemRead  in  1  instruction in EX is a load
X_branch_taken  in  1  branch/jump resolved taken in EX this cycle
X_muldiv_start  in  1  mult/div instruction entered EX this cycle
muldiv_done  in  1  multiply/divide unit result valid (single-cycle pulse)
PC_enable  out  1  PC may update
IFID_enable  out  1  IF/ID may load
IFID_flush  out  1  IF/ID loads NOP
IDEX_enable  out  1  ID/EX may load
IDEX_bubble  out  1  ID/EX loads NOP
EXMEM_bubble  out  1  EX/MEM loads NOP
halted  out  1  pipeline fully drained after HALT; sticky
muldiv_timeout  out  1  sticky error: muldiv_done never arrived

Behaviour:
- States: RUN, MULDIV_WAIT, DRAIN, HALTED. Reset → RUN. Counter cnt is 8 bits, reset 0.
- While reset=1, outputs are forced: PC_enable=0, IFID_enable=0, IDEX_enable=0, IFID_flush=1, IDEX_bubble=1, EXMEM_bubble=0, halted=0, muldiv_timeout=0.
- Outputs are combinational from state plus inputs, with zero latency. Sticky flags are registered.
- Default, RUN with no event: PC_enable=1, IFID_enable=1, IDEX_enable=1, all flush/bubble=0.
- RUN priority, highest first:
  1. X_branch_taken: IFID_flush=1, IDEX_bubble=1, PC_enable=1. Any HALT or load-use in ID is discarded; stay RUN.
  2. X_muldiv_start: cnt←0, go MULDIV_WAIT. This cycle: PC_enable=0, IFID_enable=0, IDEX_enable=0, EXMEM_bubble=1. If muldiv_done is also 1 in this cycle, stay RUN with default outputs.
  3. D_op==HALT_OPCODE: PC_enable=0, IFID_enable=0, IDEX_bubble=1, cnt←0, go DRAIN.
  4. Load-use, i.e. X_MemRead && X_rt!=0 && (X_rt==D_rs || X_rt==D_rt): PC_enable=0, IFID_enable=0, IDEX_bubble=1; stay RUN. This is a one-cycle stall; the load leaves EX next cycle. A load with X_rt==0 never stalls.
- MULDIV_WAIT:
  - PC, IFID and IDEX are frozen (enables 0); EXMEM_bubble=1; cnt increments each cycle.
  - muldiv_done=1: this cycle outputs default, go RUN.
  - cnt==MULDIV_TIMEOUT-1 without done: set muldiv_timeout, outputs default, go RUN.
  - Branch and HALT inputs are ignored; the frozen ID instruction is re-evaluated in RUN.
- DRAIN:
  - PC_enable=0, IFID_enable=0, IDEX_bubble=1; cnt increments.
  - When cnt==DRAIN_CYCLES-1, go HALTED.
  - The HALT itself never reaches EX.
- HALTED: same freeze as DRAIN, halted=1. Exit only by reset.
- Reset mid-operation (any state, any cnt) returns to RUN with cnt=0 and clears both sticky flags on the next edge.
- Simultaneous X_branch_taken and X_muldiv_start cannot legally occur; if they do, branch wins and the muldiv is treated as flushed.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state enum (2 bits);
  - HALT_OPCODE default;
  - OP_LW / OP_MULT / OP_DIV opcode constants;
  - REG_ZERO=5'd0.
- One natural sub-module, load_use_detect: pure combinational compare of X_MemRead, X_rt, D_rs, D_rt. It supersedes the existing hazard logic.
- FSM, counter and output decode stay in the top module.

Test Plan:
1. Load-use: lw $5 in EX (X_MemRead=1, X_rt=5), D_rs=5 → exactly one cycle with PC_enable=0, IFID_enable=0, IDEX_bubble=1, then default. Repeat with X_rt=0 → no stall.
2. Branch beats stall: X_branch_taken=1 with the load-use condition true and D_op=6'h3f → IFID_flush=1, IDEX_bubble=1, PC_enable=1; state stays RUN and halted never asserts.
3. Muldiv: X_muldiv_start pulse, muldiv_done 5 cycles later → 5 frozen cycles with EXMEM_bubble=1, then default outputs on the done cycle; muldiv_timeout=0.
4. Timeout: X_muldiv_start with done held 0, MULDIV_TIMEOUT=32 → muldiv_timeout rises 32 cycles after entry, FSM returns to RUN, flag stays 1 until reset.
5. Halt drain: D_op=6'h3f, DRAIN_CYCLES=3 → PC frozen from the first cycle; halted=1 after 1+3 edges and held for 20 further cycles.
6. Reset mid-DRAIN at cnt=1 → next cycle state RUN, halted=0, PC_enable=1 when inputs are idle.
